// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM skid FIFO with branch/jump redirect and misalignment flagging
module ex_mem_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic            in_is_zero,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic [1:0]      in_mem_size,
  input  logic            in_branch,
  input  logic            in_jal,
  input  logic            in_jalr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_wdata,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic [1:0]      out_mem_size,
  output logic            out_misalign,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] wdata;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [1:0]      mem_size;
    logic            misalign;
  } entry_t;
  entry_t          fifo_q [DEPTH];
  entry_t          fifo_d [DEPTH];
  entry_t          new_e;
  entry_t          head;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            push, pop, taken, link, mis;
  // decode the offered instruction into a FIFO entry; a misaligned access loses its side effects
  always_comb begin
    taken = in_jal | in_jalr | (in_branch & in_is_zero);
    link  = in_jal | in_jalr;
    mis   = (in_mem_read | in_mem_write) &
            ((in_mem_size == 2'b11) |
             ((in_mem_size == 2'b10) & (in_alu_result[1:0] != 2'b00)) |
             ((in_mem_size == 2'b01) & in_alu_result[0]));
    new_e = '{result:    link ? in_pc + XLEN'(4) : in_alu_result,
              wdata:     in_rs2_data,
              rd:        in_rd,
              reg_write: in_reg_write & ~mis,
              mem_read:  in_mem_read & ~mis,
              mem_write: in_mem_write & ~mis,
              mem_size:  in_mem_size,
              misalign:  mis};
  end
  // FIFO bookkeeping and redirect; flush empties everything and suppresses the incoming accept
  always_comb begin
    push          = in_valid & in_ready_q & ~flush;
    pop           = (count_q != '0) & out_ready & ~flush;
    fifo_d        = fifo_q;
    if (push) fifo_d[wr_ptr_q] = new_e;
    wr_ptr_d      = flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d      = flush ? '0 : rd_ptr_q + PW'(pop);
    count_d       = flush ? '0 : count_q + CW'(push) - CW'(pop);
    in_ready_d    = count_d != CW'(DEPTH);
    redirect_d    = push & taken;
    redirect_pc_d = !redirect_d ? '0 :
                    in_jalr ? {in_alu_result[XLEN-1:1], 1'b0} : in_pc + in_imm;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q        <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      in_ready_q    <= 1'b1;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      fifo_q        <= fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      in_ready_q    <= in_ready_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end
  assign in_ready      = in_ready_q;
  assign out_valid     = count_q != '0;
  assign head          = out_valid ? fifo_q[rd_ptr_q] : '0;
  assign out_result    = head.result;
  assign out_wdata     = head.wdata;
  assign out_rd        = head.rd;
  assign out_reg_write = head.reg_write;
  assign out_mem_read  = head.mem_read;
  assign out_mem_write = head.mem_write;
  assign out_mem_size  = head.mem_size;
  assign out_misalign  = head.misalign;
  assign redirect      = redirect_q;
  assign redirect_pc   = redirect_pc_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed vectors, corner sequences and a random queue-model check for ex_mem_stage
module tb_ex_mem_stage;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, flush, in_valid, in_ready, in_is_zero, in_reg_write, in_mem_read, in_mem_write;
  logic in_branch, in_jal, in_jalr, out_valid, out_ready, out_reg_write, out_mem_read;
  logic out_mem_write, out_misalign, redirect;
  logic [XLEN-1:0] in_alu_result, in_rs2_data, in_pc, in_imm, out_result, out_wdata, redirect_pc;
  logic [4:0] in_rd, out_rd;
  logic [1:0] in_mem_size, out_mem_size;
  ex_mem_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_is_zero(in_is_zero), .in_rs2_data(in_rs2_data),
    .in_pc(in_pc), .in_imm(in_imm), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_mem_size(in_mem_size),
    .in_branch(in_branch), .in_jal(in_jal), .in_jalr(in_jalr), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_wdata(out_wdata), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_mem_size(out_mem_size), .out_misalign(out_misalign), .redirect(redirect),
    .redirect_pc(redirect_pc)
  );
  typedef struct {
    logic [31:0] alu, rs2, pc, imm;
    logic [4:0]  rd;
    logic        iz, rw, mr, mw, br, jal, jalr;
    logic [1:0]  sz;
  } ins_t;
  typedef struct {
    string       name;
    ins_t        i;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw, mr, mw, mis, red;
    logic [31:0] rpc;
  } vec_t;
  typedef struct {
    logic [31:0] res, wdata;
    logic [10:0] ctrl;
  } exp_t;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic ins_t mk(input logic [31:0] alu, pc, imm, input logic [4:0] rd,
                              input logic iz, rw, mr, mw, input logic [1:0] sz,
                              input logic br, jal, jalr);
    ins_t i;
    i = '{alu: alu, rs2: alu ^ 32'hCAFE_0000, pc: pc, imm: imm, rd: rd, iz: iz, rw: rw,
          mr: mr, mw: mw, br: br, jal: jal, jalr: jalr, sz: sz};
    return i;
  endfunction
  task automatic drive(input ins_t i, input logic v);
    in_valid = v; in_alu_result = i.alu; in_rs2_data = i.rs2; in_pc = i.pc; in_imm = i.imm;
    in_rd = i.rd; in_is_zero = i.iz; in_reg_write = i.rw; in_mem_read = i.mr;
    in_mem_write = i.mw; in_mem_size = i.sz; in_branch = i.br; in_jal = i.jal; in_jalr = i.jalr;
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  function automatic logic [10:0] ctrl_now();
    return {out_rd, out_reg_write, out_mem_read, out_mem_write, out_mem_size, out_misalign};
  endfunction
  function automatic exp_t model_ent(input ins_t i);
    exp_t e;
    int align;
    bit bad;
    align = 1 << i.sz;
    bad   = (i.mr || i.mw) && (i.sz == 2'd3 || (i.alu % align) != 0);
    e.res   = (i.jal || i.jalr) ? i.pc + 32'd4 : i.alu;
    e.wdata = i.rs2;
    e.ctrl  = {i.rd, i.rw && !bad, i.mr && !bad, i.mw && !bad, i.sz, bad};
    return e;
  endfunction
  function automatic ins_t rand_ins();
    ins_t i;
    int t;
    t = $urandom_range(0, 5);
    i = mk($urandom, $urandom & 32'hFFFF_FFFC, $urandom, 5'($urandom), 1'($urandom),
           t inside {0, 1, 4, 5}, t == 1, t == 2, 2'($urandom), t == 3, t == 4, t == 5);
    i.rs2 = $urandom;
    return i;
  endfunction
  vec_t vt[11];
  ins_t idle, a, b, c, r;
  exp_t mq[$];
  bit m_ready, m_red, acc, pop, v, ordy, fl;
  logic [31:0] m_rpc;
  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[0]  = '{"add",   mk(32'h10, 32'h40, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0), 32'h10, 5, 1, 0, 0, 0, 0, 0};
    vt[1]  = '{"beq_t", mk(0, 32'h100, 32'h20, 0, 1, 0, 0, 0, 0, 1, 0, 0), 0, 0, 0, 0, 0, 0, 1, 32'h120};
    vt[2]  = '{"beq_n", mk(7, 32'h100, 32'h20, 0, 0, 0, 0, 0, 0, 1, 0, 0), 7, 0, 0, 0, 0, 0, 0, 0};
    vt[3]  = '{"jalr",  mk(32'h305, 32'h200, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1), 32'h204, 1, 1, 0, 0, 0, 1, 32'h304};
    vt[4]  = '{"lw_mis", mk(32'h1002, 32'h10, 0, 7, 0, 1, 1, 0, 2, 0, 0, 0), 32'h1002, 7, 0, 0, 0, 1, 0, 0};
    vt[5]  = '{"lh_ok", mk(32'h1002, 32'h10, 0, 7, 0, 1, 1, 0, 1, 0, 0, 0), 32'h1002, 7, 1, 1, 0, 0, 0, 0};
    vt[6]  = '{"jal_neg", mk(9, 32'h300, 32'hFFFF_FFF0, 3, 0, 1, 0, 0, 0, 0, 1, 0), 32'h304, 3, 1, 0, 0, 0, 1, 32'h2F0};
    vt[7]  = '{"sw_mis", mk(32'h1001, 32'h10, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0), 32'h1001, 0, 0, 0, 0, 1, 0, 0};
    vt[8]  = '{"sb_ok", mk(32'h1003, 32'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 32'h1003, 0, 0, 0, 1, 0, 0, 0};
    vt[9]  = '{"sz11",  mk(32'h2000, 32'h10, 0, 4, 0, 1, 1, 0, 3, 0, 0, 0), 32'h2000, 4, 0, 0, 0, 1, 0, 0};
    vt[10] = '{"beq_wrap", mk(0, 32'hFFFF_FFF0, 32'h20, 0, 1, 0, 0, 0, 0, 1, 0, 0), 0, 0, 0, 0, 0, 0, 1, 32'h10};
    rst = 1; flush = 0; out_ready = 0; drive(idle, 0);
    @(negedge clk); step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_redirect", redirect, 0);
    chk("rst_data", {out_result, out_wdata}, 0);
    chk("rst_ctrl", ctrl_now(), 0);
    chk("rst_rpc", redirect_pc, 0);
    rst = 0;
    step();
    foreach (vt[k]) begin
      out_ready = 1;
      drive(vt[k].i, 1);
      step();
      drive(idle, 0);
      chk({vt[k].name, "_valid"}, out_valid, 1);
      chk({vt[k].name, "_result"}, out_result, vt[k].res);
      chk({vt[k].name, "_wdata"}, out_wdata, vt[k].i.rs2);
      chk({vt[k].name, "_ctrl"}, ctrl_now(),
          {vt[k].rd, vt[k].rw, vt[k].mr, vt[k].mw, vt[k].i.sz, vt[k].mis});
      chk({vt[k].name, "_redirect"}, redirect, vt[k].red);
      if (vt[k].red) chk({vt[k].name, "_rpc"}, redirect_pc, vt[k].rpc);
      step();
      chk({vt[k].name, "_redirect_drop"}, redirect, 0);
      chk({vt[k].name, "_popped"}, out_valid, 0);
    end
    a = mk(32'hA, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    b = mk(32'hB, 0, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0);
    c = mk(32'hC, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    out_ready = 0;
    drive(a, 1); step();
    chk("fill1_ready", in_ready, 1); chk("fill1_rd", out_rd, 1);
    drive(b, 1); step();
    chk("fill2_ready", in_ready, 0); chk("fill2_rd", out_rd, 1);
    drive(c, 1); step();
    chk("fill3_ready", in_ready, 0); chk("fill3_stable_rd", out_rd, 1);
    drive(idle, 0); out_ready = 1; step();
    chk("drain1_ready", in_ready, 1); chk("drain1_rd", out_rd, 2); chk("drain1_res", out_result, 32'hB);
    step();
    chk("drain2_empty", out_valid, 0);
    out_ready = 0;
    drive(a, 1); step(); drive(b, 1); step();
    chk("full_before_flush", in_ready, 0);
    drive(mk(0, 32'h100, 32'h20, 0, 1, 0, 0, 0, 0, 1, 0, 0), 1); flush = 1; step();
    flush = 0; drive(idle, 0);
    chk("flush_valid", out_valid, 0); chk("flush_redirect", redirect, 0); chk("flush_ready", in_ready, 1);
    drive(mk(0, 32'h100, 32'h8, 0, 0, 1, 0, 0, 0, 0, 1, 0), 1); flush = 1; step();
    flush = 0; drive(idle, 0);
    chk("flush_drop_valid", out_valid, 0); chk("flush_drop_redirect", redirect, 0);
    drive(mk(0, 32'h100, 32'h8, 0, 0, 1, 0, 0, 0, 0, 1, 0), 1); step();
    drive(idle, 0);
    chk("stall_redirect", redirect, 1); chk("stall_rpc", redirect_pc, 32'h108);
    step();
    chk("stall_redirect_drop", redirect, 0); chk("stall_held", out_valid, 1);
    rst = 1; step(); rst = 0;
    m_ready = 1; m_red = 0; m_rpc = 0; mq.delete();
    for (int n = 0; n < 600; n++) begin
      chk("rnd_valid", out_valid, mq.size() != 0);
      chk("rnd_ready", in_ready, m_ready);
      chk("rnd_redirect", redirect, m_red);
      if (m_red) chk("rnd_rpc", redirect_pc, m_rpc);
      if (mq.size() != 0) begin
        chk("rnd_result", out_result, mq[0].res);
        chk("rnd_wdata", out_wdata, mq[0].wdata);
        chk("rnd_ctrl", ctrl_now(), mq[0].ctrl);
      end
      r = rand_ins();
      v = $urandom_range(0, 9) < 7;
      ordy = $urandom_range(0, 9) < 6;
      fl = $urandom_range(0, 19) == 0;
      drive(r, v); out_ready = ordy; flush = fl;
      acc = v && m_ready && !fl;
      pop = mq.size() != 0 && ordy && !fl;
      m_red = acc && (r.jal || r.jalr || (r.br && r.iz));
      m_rpc = r.jalr ? r.alu & ~32'd1 : r.pc + r.imm;
      if (fl) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(model_ent(r));
      end
      m_ready = mq.size() < DEPTH;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
